// File: rtl/trace_capture_buffer_if.sv
// trace_capture_buffer_if
// Read-side handshake of the trace capture buffer.
//   rd_valid  buffer holds at least one entry (driven by the buffer)
//   rd_pc     PC of the head entry, 0 while empty
//   rd_instr  instruction of the head entry, 0 while empty
//   rd_ready  consumer accepts the head entry this cycle
// The buffer uses the master modport; a consumer (bench, UART dumper)
// uses the slave modport.
interface trace_capture_buffer_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;

  modport master (output rd_valid, output rd_pc, output rd_instr, input rd_ready);
  modport slave  (input rd_valid, input rd_pc, input rd_instr, output rd_ready);
endinterface

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer
// Records one {PC, instruction} pair per retired instruction of the
// single-cycle core into a first-word-fall-through FIFO. A capture session
// is started by arm (optionally waiting for a trigger PC) and ends on stop
// or when the core is seen spinning on the same instruction for
// HALT_CYCLES consecutive repeats.
// Ports:
//   clk                system clock, rising edge
//   reset              asynchronous, active-low reset
//   debug_pc           core PC for the current cycle
//   debug_instruction  core instruction for the current cycle
//   arm                pulse: flush and start a capture session
//   stop               pulse: end the capture session
//   trig_en            1 = wait for trig_pc before capturing (sampled on arm)
//   trig_pc            trigger PC
//   rd                 read port (valid/ready, head PC and instruction)
//   count              number of occupied entries
//   state              0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   overflow           sticky: a sample was dropped on a full FIFO
//   halted             sticky: self-loop halt detected
module trace_capture_buffer #(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  debug_pc,
  input  logic [31:0]                  debug_instruction,
  input  logic                         arm,
  input  logic                         stop,
  input  logic                         trig_en,
  input  logic [31:0]                  trig_pc,
  trace_capture_buffer_if.master       rd,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [1:0]                   state,
  output logic                         overflow,
  output logic                         halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = $clog2(HALT_CYCLES+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          st;
  logic [63:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [63:0]     prev;
  logic            prev_valid;
  logic [RW-1:0]   rep_cnt;

  logic [63:0]     sample;
  logic            trig_hit;
  logic            sampling;
  logic            repeat_hit;
  logic            halt_hit;
  logic            pop;
  logic            push_req;
  logic            push;
  logic            drop;

  assign sample = {debug_pc, debug_instruction};

  // A stop in ARMED wins over a coincident trigger match, so the matching
  // sample is only taken when the session actually moves to CAPTURE.
  assign trig_hit = (st == ARMED) && !stop && (debug_pc == trig_pc);

  // arm flushes the buffer, so nothing is sampled or popped in that cycle.
  assign sampling   = !arm && ((st == CAPTURE) || trig_hit);
  assign repeat_hit = sampling && prev_valid && (sample == prev);
  assign halt_hit   = repeat_hit && (rep_cnt == RW'(HALT_CYCLES - 1));
  assign pop        = rd.rd_valid && rd.rd_ready && !arm;
  assign push_req   = sampling && !repeat_hit;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push = push_req && ((count != CW'(DEPTH)) || pop);
  assign drop = push_req && !push;

  // FWFT head: combinational view of the oldest entry, forced to 0 when empty.
  assign rd.rd_valid = (count != '0);
  assign rd.rd_pc    = rd.rd_valid ? mem[rd_ptr][63:32] : 32'h0;
  assign rd.rd_instr = rd.rd_valid ? mem[rd_ptr][31:0]  : 32'h0;

  assign state = st;

  // Storage array carries no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample;
    end
  end

  // Session FSM, FIFO bookkeeping and halt detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      halted     <= 1'b0;
      rep_cnt    <= '0;
      prev_valid <= 1'b0;
      prev       <= '0;
    end else if (arm) begin
      st         <= trig_en ? ARMED : CAPTURE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      halted     <= 1'b0;
      rep_cnt    <= '0;
      prev_valid <= 1'b0;
    end else begin
      case (st)
        ARMED: begin
          if (stop) begin
            st <= DONE;
          end else if (trig_hit) begin
            st <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop || halt_hit) begin
            st <= DONE;
          end
        end
        default: begin
        end
      endcase

      if (sampling) begin
        prev       <= sample;
        prev_valid <= 1'b1;
        rep_cnt    <= repeat_hit ? rep_cnt + 1'b1 : '0;
      end

      if (halt_hit) begin
        halted <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer
// Self-checking bench for trace_capture_buffer. A queue-based model of the
// capture session is advanced on every rising edge and compared against
// every DUT output on each falling edge. Directed scenarios pin the model
// with hand-computed literals, then a long randomized phase exercises
// arm/stop/trigger/halt/overflow/async-reset interactions.
module tb_trace_capture_buffer;

  localparam int DEPTH = 16;
  localparam int HALT  = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   debug_pc = '0;
  logic [31:0]   debug_instruction = '0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic          trig_en = 1'b0;
  logic [31:0]   trig_pc = '0;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic          overflow;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  trace_capture_buffer_if rd ();

  trace_capture_buffer #(
    .DEPTH       (DEPTH),
    .HALT_CYCLES (HALT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .debug_pc          (debug_pc),
    .debug_instruction (debug_instruction),
    .arm               (arm),
    .stop              (stop),
    .trig_en           (trig_en),
    .trig_pc           (trig_pc),
    .rd                (rd.master),
    .count             (count),
    .state             (state),
    .overflow          (overflow),
    .halted            (halted)
  );

  always #5 clk = ~clk;

  // Reference model: session state as an int, FIFO as a queue of {pc,instr}.
  logic [63:0] m_q[$];
  int          m_state = 0;
  bit          m_ovf = 1'b0;
  bit          m_hlt = 1'b0;
  bit          m_pv = 1'b0;
  logic [63:0] m_prev = '0;
  int          m_rep = 0;

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_hlt   = 1'b0;
    m_pv    = 1'b0;
    m_rep   = 0;
  endtask

  task automatic model_step();
    logic [63:0] smp;
    bit take;
    bit push;
    bit pop;
    int nst;
    smp = {debug_pc, debug_instruction};
    if (arm) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_hlt   = 1'b0;
      m_rep   = 0;
      m_pv    = 1'b0;
      m_state = trig_en ? 1 : 2;
      return;
    end
    pop  = (m_q.size() != 0) && (rd.rd_ready === 1'b1);
    nst  = m_state;
    take = 1'b0;
    if (m_state == 1) begin
      if (stop) nst = 3;
      else if (debug_pc == trig_pc) begin
        nst  = 2;
        take = 1'b1;
      end
    end else if (m_state == 2) begin
      take = 1'b1;
      if (stop) nst = 3;
    end
    push = 1'b0;
    if (take) begin
      if (m_pv && smp == m_prev) begin
        m_rep++;
        if (m_rep == HALT) begin
          m_hlt = 1'b1;
          nst   = 3;
        end
      end else begin
        m_rep = 0;
        push  = 1'b1;
      end
      m_prev = smp;
      m_pv   = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(smp);
      else m_ovf = 1'b1;
    end
    m_state = nst;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic compare_all();
    logic [31:0] e_pc;
    logic [31:0] e_in;
    e_pc = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    e_in = (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
    check("model.state",    32'(state),       32'(m_state));
    check("model.count",    32'(count),       32'(m_q.size()));
    check("model.rd_valid", 32'(rd.rd_valid), 32'(m_q.size() != 0));
    check("model.rd_pc",    rd.rd_pc,         e_pc);
    check("model.rd_instr", rd.rd_instr,      e_in);
    check("model.overflow", 32'(overflow),    32'(m_ovf));
    check("model.halted",   32'(halted),      32'(m_hlt));
  endtask

  always @(negedge clk) compare_all();

  // Drive one cycle of inputs, then return just after the consuming edge.
  task automatic apply_cycle(input logic [31:0] pc, input logic [31:0] ins,
                             input logic a, input logic s, input logic rdy);
    debug_pc          = pc;
    debug_instruction = ins;
    arm               = a;
    stop              = s;
    rd.rd_ready       = rdy;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] instrs [3];
  logic [31:0] cur_pc;
  logic [31:0] cur_in;

  initial begin
    instrs[0] = 32'h00500093;
    instrs[1] = 32'h00A00113;
    instrs[2] = 32'h002081B3;
    rd.rd_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("reset.state",    32'(state),       32'd0);
    check("reset.count",    32'(count),       32'd0);
    check("reset.rd_valid", 32'(rd.rd_valid), 32'd0);
    check("reset.rd_pc",    rd.rd_pc,         32'h0);
    reset = 1'b1;
    apply_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Untriggered capture of three instructions, then readout
    trig_en = 1'b0;
    apply_cycle(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t1.state_after_arm", 32'(state), 32'd2);
    for (int i = 0; i < 3; i++) apply_cycle(32'(4*i), instrs[i], 1'b0, 1'b0, 1'b0);
    check("t1.count", 32'(count), 32'd3);
    check("t1.state", 32'(state), 32'd2);
    apply_cycle(32'h8, instrs[2], 1'b0, 1'b1, 1'b0);
    check("t1.state_stop", 32'(state), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t1.rd_pc",    rd.rd_pc,    32'(4*i));
      check("t1.rd_instr", rd.rd_instr, instrs[i]);
      apply_cycle(32'h8, instrs[2], 1'b0, 1'b0, 1'b1);
    end
    check("t1.rd_valid_empty", 32'(rd.rd_valid), 32'd0);

    // Triggered capture starting at PC 0x10
    trig_en = 1'b1;
    trig_pc = 32'h10;
    apply_cycle(32'h0, 32'h13, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_cycle(32'(4*i), 32'h13, 1'b0, 1'b0, 1'b0);
      check("t2.state_armed", 32'(state), 32'd1);
    end
    apply_cycle(32'h10, 32'h13, 1'b0, 1'b0, 1'b0);
    check("t2.state_trig", 32'(state), 32'd2);
    check("t2.count_trig", 32'(count), 32'd1);
    apply_cycle(32'h14, 32'h13, 1'b0, 1'b0, 1'b0);
    apply_cycle(32'h18, 32'h13, 1'b0, 1'b0, 1'b0);
    check("t2.count", 32'(count), 32'd3);
    check("t2.head_pc", rd.rd_pc, 32'h10);
    apply_cycle(32'h18, 32'h13, 1'b0, 1'b1, 1'b0);

    // Overflow, then a full-FIFO push accepted alongside a pop
    trig_en = 1'b0;
    apply_cycle(32'h0, 32'h13, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) apply_cycle(32'(4*i), 32'h13, 1'b0, 1'b0, 1'b0);
    check("t3.count_full", 32'(count),    32'd16);
    check("t3.overflow",   32'(overflow), 32'd1);
    check("t3.head_pc",    rd.rd_pc,      32'h0);
    apply_cycle(32'h50, 32'h13, 1'b0, 1'b0, 1'b1);
    check("t3.count_poppush", 32'(count), 32'd16);
    check("t3.head_after_pop", rd.rd_pc,  32'h4);
    apply_cycle(32'h50, 32'h13, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("t3.drain_pc", rd.rd_pc, (i < 15) ? 32'(4 + 4*i) : 32'h50);
      apply_cycle(32'h50, 32'h13, 1'b0, 1'b0, 1'b1);
    end
    check("t3.drained", 32'(rd.rd_valid), 32'd0);

    // Self-loop halt: jal x0,0 at 0x20 held five cycles
    apply_cycle(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply_cycle(32'h20, 32'h6F, 1'b0, 1'b0, 1'b0);
    check("t4.halted_early", 32'(halted), 32'd0);
    check("t4.state_early",  32'(state),  32'd2);
    apply_cycle(32'h20, 32'h6F, 1'b0, 1'b0, 1'b0);
    check("t4.halted", 32'(halted), 32'd1);
    check("t4.state",  32'(state),  32'd3);
    check("t4.count",  32'(count),  32'd1);
    apply_cycle(32'h24, 32'h13, 1'b0, 1'b0, 1'b0);
    check("t4.no_push_done", 32'(count), 32'd1);

    // stop with five entries, then re-arm flushes
    apply_cycle(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t5.halted_cleared", 32'(halted), 32'd0);
    for (int i = 0; i < 5; i++) apply_cycle(32'(4*i), 32'h13, 1'b0, 1'b0, 1'b0);
    apply_cycle(32'h10, 32'h13, 1'b0, 1'b1, 1'b0);
    check("t5.state_stop", 32'(state), 32'd3);
    apply_cycle(32'h40, 32'h13, 1'b0, 1'b0, 1'b0);
    apply_cycle(32'h44, 32'h13, 1'b0, 1'b0, 1'b0);
    check("t5.count_kept", 32'(count), 32'd5);
    apply_cycle(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t5.count_flush", 32'(count),    32'd0);
    check("t5.ovf_flush",   32'(overflow), 32'd0);

    // Asynchronous reset mid-capture
    for (int i = 0; i < 7; i++) apply_cycle(32'(4*i), 32'h13, 1'b0, 1'b0, 1'b0);
    check("t6.count_pre", 32'(count), 32'd7);
    reset = 1'b0;
    #1;
    check("t6.state",    32'(state),       32'd0);
    check("t6.count",    32'(count),       32'd0);
    check("t6.rd_valid", 32'(rd.rd_valid), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Randomized session traffic against the model
    cur_pc = 32'h100;
    cur_in = 32'h13;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cur_pc = 32'h100 + 32'(4 * $urandom_range(0, 7));
        cur_in = ($urandom_range(0, 1) == 0) ? 32'h13 : 32'h6F;
      end
      trig_en = 1'($urandom_range(0, 1));
      trig_pc = 32'h100 + 32'(4 * $urandom_range(0, 7));
      apply_cycle(cur_pc, cur_in,
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 59) == 0),
                  (i < 1500) ? 1'($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 4) < 3));
      if (i == 1700) begin
        reset = 1'b0;
        #1;
        check("rand.async_count", 32'(count), 32'd0);
        #1;
        reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Sits directly downstream of the single-cycle RISC-V core and consumes its debug_pc / debug_instruction outputs.
- Records one {PC, instruction} entry per retired instruction into a first-word-fall-through (FWFT) FIFO.
- Supports an optional PC trigger and self-loop halt detection.
- The FIFO is drained through a valid/ready read port by the testbench or a UART dumper.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >=2.
- HALT_CYCLES, 4, consecutive identical repeat samples that flag a halt; >=1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- debug_pc  in  32  core PC for the current cycle.
- debug_instruction  in  32  core instruction for the current cycle.
- arm  in  1  single-cycle pulse; flushes the buffer and starts a capture session.
- stop  in  1  single-cycle pulse; ends the capture session.
- trig_en  in  1  1 = wait for trig_pc before capturing; sampled on arm.
- trig_pc  in  32  trigger PC value.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  FIFO not empty.
- rd_pc  out  32  head entry PC.
- rd_instr  out  32  head entry instruction.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- overflow  out  1  sticky; at least one sample was dropped because the FIFO was full.
- halted  out  1  sticky; self-loop halt detected.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, rd_valid=0, overflow=0, halted=0, rep_cnt=0, prev_valid=0. rd_pc and rd_instr read 0 while empty.
- FSM (registered):
  - IDLE --arm--> ARMED when trig_en=1; IDLE --arm--> CAPTURE when trig_en=0.
  - ARMED --(debug_pc==trig_pc)--> CAPTURE. The matching sample is pushed in the same cycle.
  - CAPTURE --stop--> DONE.
  - CAPTURE --halt detect--> DONE.
  - ARMED --stop--> DONE.
  - arm in any state: flush (count=0, pointers=0), clear overflow, halted, rep_cnt and prev_valid, then enter ARMED or CAPTURE per trig_en. arm has priority over stop and over pop.
  - DONE and IDLE: no pushes; reads continue.
- Sampling, CAPTURE only (plus the trigger cycle):
  - sample = {debug_pc, debug_instruction}. Compare it against prev (the previous cycle's sample, registered whenever capturing).
  - If prev_valid and sample==prev: rep_cnt++, no push.
  - Otherwise: rep_cnt=0, push.
  - When rep_cnt increments to HALT_CYCLES: halted=1, next state DONE.
- Push/pop:
  - pop = rd_valid & rd_ready.
  - A push is accepted if count<DEPTH or pop happens in the same cycle. Otherwise the sample is dropped and overflow=1; capture continues.
  - Simultaneous push and pop leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: a sample pushed at edge N is visible on rd_valid/rd_pc/rd_instr after edge N (FWFT, combinational read of the head).
- Reset asserted mid-session: immediate return to reset values; FIFO contents discarded.

Test Plan:
- Reset, then arm with trig_en=0; core drives PC 0x00,0x04,0x08 with instrs 0x00500093,0x00A00113,0x002081B3; rd_ready=0 -> count=3, state=2; reading with rd_ready=1 yields the three pairs in order, then rd_valid=0.
- trig_en=1, trig_pc=0x10, PCs 0x00..0x18 step 4 -> state=1 until PC 0x10; first entry is PC=0x10; count=3 after PC 0x18.
- DEPTH=16, rd_ready=0, 20 distinct PCs -> count=16, overflow=1, entries are PC 0x00..0x3C. Then rd_ready=1 for one cycle while the next distinct sample arrives -> count stays 16, the new sample is stored.
- PC 0x20 / instr 0x0000006F (jal x0,0) held 5 cycles with HALT_CYCLES=4 -> a single entry pushed, halted=1 and state=3 after the 5th edge, no further pushes.
- stop during CAPTURE with count=5 -> state=3; later PCs are not captured; count=5. A subsequent arm flushes -> count=0, overflow=0, halted=0.
- Assert reset (0) asynchronously mid-CAPTURE with count=7 -> outputs immediately read state=0, count=0, rd_valid=0 without waiting for a clock edge.
